traffic_phase_sequencer: RTL and testbench
==========================================

// Module: traffic_phase_sequencer
// PURPOSE
//   Parametrised traffic-light controller for N_WAYS approaches. Successor to the fixed 3-lamp controller.
//   Sequences one approach at a time through GREEN -> YELLOW -> ALL_RED, selects the next approach round-robin from demand.
//   Adds green hold, flashing-yellow mode and an optional pedestrian walk phase. Top-level lamp driver in the sim/ tree.
// PARAMETERS
//   N_WAYS      2   number of approaches (>=2)
//   GREEN_CYC   8   minimum green duration, cycles (>=1)
//   YELLOW_CYC  3   yellow duration, cycles (>=1)
//   ALLRED_CYC  2   all-red clearance duration, cycles (>=1)
//   FLASH_CYC   4   half-period of flashing yellow, cycles (>=1)
//   WALK_CYC    6   pedestrian walk duration, cycles (used only with TRAFFIC_PED_EN)
// PORTS
//   clk         in   1                 clock; all state changes on posedge
//   rst         in   1                 synchronous active-low reset: sampled at posedge, rst==0 resets
//   flash       in   1                 level; 1 = flashing-yellow mode
//   demand      in   N_WAYS            level; per-approach vehicle request
//   red         out  N_WAYS            per-approach red lamp
//   yellow      out  N_WAYS            per-approach yellow lamp
//   green       out  N_WAYS            per-approach green lamp
//   active_way  out  $clog2(N_WAYS)    approach currently owning the sequence
//   phase       out  3                 current phase_t encoding
//   ped_req     in   1                 [TRAFFIC_PED_EN only] pedestrian button, any pulse width
//   walk        out  1                 [TRAFFIC_PED_EN only] walk lamp
// BEHAVIOUR
//   - Reset (rst==0 at posedge, overrides everything): phase=ALL_RED, active_way=N_WAYS-1, timer=ALLRED_CYC-1,
//     red=all 1, yellow=0, green=0, walk=0, ped_pend=0.
//   - Outputs are decoded only from registered phase/active_way. Lamps change on the same edge as phase.
//   - Timer: down-counter wide enough for the largest duration. On entry to a phase, load duration-1.
//     The phase exits at the posedge where timer==0, so a phase lasts exactly its duration in cycles.
//   - GREEN: green[way]=1, red[way']=1 for every other way. At timer==0, hold GREEN while demand[way]==1 and
//     (demand & ~onehot(way))==0. Otherwise -> YELLOW.
//   - YELLOW: yellow[way]=1, red[way']=1 for every other way. At timer==0 -> ALL_RED.
//   - ALL_RED: red all 1. At timer==0 -> GREEN on the next way, chosen as the first set demand bit scanning way+1,
//     way+2 .. wrapping back to way. If demand==0, the next way is way+1 mod N_WAYS.
//   - demand is sampled only at decision edges (GREEN/ALL_RED exit); it is not latched.
//   - FLASH: flash==1 at any posedge (rst==1) forces FLASH on that edge. In FLASH, red=0, green=0, and
//     yellow=all 1 / all 0, toggling every FLASH_CYC cycles and starting at all 1.
//     On the edge flash==0 is sampled -> ALL_RED with active_way=N_WAYS-1 and full ALLRED_CYC, so way 0 greens next.
//   - Invariants: at most one bit set across green|yellow. GREEN is always followed by YELLOW then ALL_RED.
//     No lamp is X after reset.
// CONFIGURATION
//   - TRAFFIC_PED_EN defined: adds ped_req/walk. A ped_req sampled high sets the sticky ped_pend.
//     At ALL_RED exit with ped_pend=1 -> WALK instead of GREEN. WALK: red all 1, walk=1, ped_pend cleared on entry,
//     WALK_CYC cycles, then ALL_RED (full ALLRED_CYC), then next-way selection as normal.
//     ped_req during WALK re-arms ped_pend. FLASH and reset both clear ped_pend.
//   - TRAFFIC_PED_EN undefined: no ped_req/walk ports, no WALK state. WALK_CYC is ignored.
// STRUCTURE
//   - traffic_pkg: typedef enum logic[2:0] phase_t {PH_ALL_RED=0, PH_GREEN=1, PH_YELLOW=2, PH_FLASH=3, PH_WALK=4};
//     plus default duration localparams.
//   - Sub-module traffic_rr_pick: combinational round-robin next-way picker (demand, way -> next_way).
// TESTING (defaults: N_WAYS=2, G=8, Y=3, AR=2, F=4, W=6)
//   1 rst=0 2 cycles, release, demand=11 -> red=11 2 cyc, G0 8, Y0 3, AR 2, G1 8 ...; 26-cycle period, green never 11.
//   2 demand=01 -> green[0] held past cycle 10; set demand[1] at cycle 20 -> yellow=01 on next edge, then AR 2, green=10.
//   3 demand=00 -> plain rotation 0,1,0 with 26-cycle period; no green hold.
//   4 flash=1 during G0 -> next edge green=00, yellow=11 4 cyc, 00 4 cyc ...; flash=0 -> red=11 2 cyc, then green=01.
//   5 rst=0 for 1 cycle mid Y1 -> next edge red=11, yellow=00, active_way=1, then green[0] after 2 cycles.
//   6 [TRAFFIC_PED_EN] 1-cycle ped_req during G0 -> Y0 3, AR 2, walk=1 6 cyc with red=11, AR 2, green=10.

Source files
------------

// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared types and default timings for the traffic phase sequencer.
// Optional pedestrian walk phase is enabled with `define TRAFFIC_PED_EN.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_ALL_RED = 3'd0,
        PH_GREEN   = 3'd1,
        PH_YELLOW  = 3'd2,
        PH_FLASH   = 3'd3,
        PH_WALK    = 3'd4
    } phase_t;

    localparam int unsigned DEF_N_WAYS     = 2;
    localparam int unsigned DEF_GREEN_CYC  = 8;
    localparam int unsigned DEF_YELLOW_CYC = 3;
    localparam int unsigned DEF_ALLRED_CYC = 2;
    localparam int unsigned DEF_FLASH_CYC  = 4;
    localparam int unsigned DEF_WALK_CYC   = 6;

    function automatic int unsigned max_dur(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d,
                                            input int unsigned e);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // Timer only ever holds duration-1, so $clog2(max) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned max_v);
        return (max_v < 2) ? 1 : $clog2(max_v);
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// Lamp/demand bundle between the sequencer and its controller side.
// ped_req/walk exist only when TRAFFIC_PED_EN is defined.
interface traffic_phase_sequencer_if
    import traffic_pkg::*;
#(
    parameter int unsigned N_WAYS = DEF_N_WAYS
);
    localparam int unsigned WAY_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;

    logic              flash;
    logic [N_WAYS-1:0] demand;
    logic [N_WAYS-1:0] red;
    logic [N_WAYS-1:0] yellow;
    logic [N_WAYS-1:0] green;
    logic [WAY_W-1:0]  active_way;
    phase_t            phase;
`ifdef TRAFFIC_PED_EN
    logic              ped_req;
    logic              walk;
`endif

    modport master (
`ifdef TRAFFIC_PED_EN
        output ped_req,
        input  walk,
`endif
        output flash, demand,
        input  red, yellow, green, active_way, phase
    );

    modport slave (
`ifdef TRAFFIC_PED_EN
        input  ped_req,
        output walk,
`endif
        input  flash, demand,
        output red, yellow, green, active_way, phase
    );

endinterface

// File: rtl/traffic_phase_sequencer_rr_pick.sv
// Combinational round-robin picker: first demanding way after 'way',
// wrapping back to 'way' itself; way+1 when nothing is demanded.
module traffic_rr_pick #(
    parameter int unsigned N_WAYS = 2,
    parameter int unsigned WAY_W  = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
    input  logic [N_WAYS-1:0] demand,
    input  logic [WAY_W-1:0]  way,
    output logic [WAY_W-1:0]  next_way
);

    logic        found;
    int unsigned idx;

    always_comb begin
        next_way = (32'(way) == N_WAYS - 1) ? '0 : way + 1'b1;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 1; i <= N_WAYS; i++) begin
            idx = (32'(way) + i) % N_WAYS;
            for (int unsigned j = 0; j < N_WAYS; j++) begin
                if (!found && j == idx && demand[j]) begin
                    found    = 1'b1;
                    next_way = WAY_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Round-robin traffic phase sequencer with green hold and flashing-yellow mode.
// Define TRAFFIC_PED_EN to add the pedestrian walk phase (ped_req/walk).
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned N_WAYS     = DEF_N_WAYS,
    parameter int unsigned GREEN_CYC  = DEF_GREEN_CYC,
    parameter int unsigned YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int unsigned ALLRED_CYC = DEF_ALLRED_CYC,
    parameter int unsigned FLASH_CYC  = DEF_FLASH_CYC,
    parameter int unsigned WALK_CYC   = DEF_WALK_CYC
) (
    input logic                      clk,
    input logic                      rst,
    traffic_phase_sequencer_if.slave bus
);

    localparam int unsigned WAY_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
    localparam int unsigned TMR_W =
        cnt_width(max_dur(GREEN_CYC, YELLOW_CYC, ALLRED_CYC, FLASH_CYC, WALK_CYC));

    localparam logic [TMR_W-1:0] G_LOAD  = TMR_W'(GREEN_CYC - 1);
    localparam logic [TMR_W-1:0] Y_LOAD  = TMR_W'(YELLOW_CYC - 1);
    localparam logic [TMR_W-1:0] AR_LOAD = TMR_W'(ALLRED_CYC - 1);
    localparam logic [TMR_W-1:0] F_LOAD  = TMR_W'(FLASH_CYC - 1);
`ifdef TRAFFIC_PED_EN
    localparam logic [TMR_W-1:0] W_LOAD  = TMR_W'(WALK_CYC - 1);
`endif

    phase_t            phase_q;
    logic [WAY_W-1:0]  way_q;
    logic [TMR_W-1:0]  timer_q;
    logic [N_WAYS-1:0] red_q;
    logic [N_WAYS-1:0] yellow_q;
    logic [N_WAYS-1:0] green_q;
    logic [WAY_W-1:0]  next_way;
`ifdef TRAFFIC_PED_EN
    logic              ped_pend_q;
    logic              walk_q;
`endif

    function automatic logic [N_WAYS-1:0] onehot(input logic [WAY_W-1:0] w);
        logic [N_WAYS-1:0] oh;
        for (int unsigned i = 0; i < N_WAYS; i++) oh[i] = (32'(w) == i);
        return oh;
    endfunction

    traffic_rr_pick #(
        .N_WAYS (N_WAYS),
        .WAY_W  (WAY_W)
    ) u_pick (
        .demand   (bus.demand),
        .way      (way_q),
        .next_way (next_way)
    );

    // Lamps are registered alongside the phase so they change on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q  <= PH_ALL_RED;
            way_q    <= WAY_W'(N_WAYS - 1);
            timer_q  <= AR_LOAD;
            red_q    <= '1;
            yellow_q <= '0;
            green_q  <= '0;
`ifdef TRAFFIC_PED_EN
            ped_pend_q <= 1'b0;
            walk_q     <= 1'b0;
`endif
        end else if (bus.flash) begin
            red_q   <= '0;
            green_q <= '0;
`ifdef TRAFFIC_PED_EN
            ped_pend_q <= 1'b0;
            walk_q     <= 1'b0;
`endif
            if (phase_q != PH_FLASH) begin
                phase_q  <= PH_FLASH;
                timer_q  <= F_LOAD;
                yellow_q <= '1;
            end else if (timer_q == '0) begin
                timer_q  <= F_LOAD;
                yellow_q <= ~yellow_q;
            end else begin
                timer_q <= timer_q - 1'b1;
            end
        end else begin
`ifdef TRAFFIC_PED_EN
            if (bus.ped_req) ped_pend_q <= 1'b1;
`endif
            if (phase_q == PH_FLASH) begin
                // Leaving flash restarts clearance as if way N_WAYS-1 just finished.
                phase_q  <= PH_ALL_RED;
                way_q    <= WAY_W'(N_WAYS - 1);
                timer_q  <= AR_LOAD;
                red_q    <= '1;
                yellow_q <= '0;
                green_q  <= '0;
            end else if (timer_q != '0) begin
                timer_q <= timer_q - 1'b1;
            end else begin
                case (phase_q)
                    PH_GREEN: begin
                        // Hold green (timer parked at 0) while only this way wants it.
                        if (!((bus.demand & onehot(way_q)) != '0 &&
                              (bus.demand & ~onehot(way_q)) == '0)) begin
                            phase_q  <= PH_YELLOW;
                            timer_q  <= Y_LOAD;
                            yellow_q <= onehot(way_q);
                            green_q  <= '0;
                        end
                    end
                    PH_YELLOW: begin
                        phase_q  <= PH_ALL_RED;
                        timer_q  <= AR_LOAD;
                        red_q    <= '1;
                        yellow_q <= '0;
                    end
                    PH_ALL_RED: begin
`ifdef TRAFFIC_PED_EN
                        if (ped_pend_q) begin
                            phase_q    <= PH_WALK;
                            timer_q    <= W_LOAD;
                            walk_q     <= 1'b1;
                            ped_pend_q <= 1'b0;
                        end else begin
                            phase_q <= PH_GREEN;
                            way_q   <= next_way;
                            timer_q <= G_LOAD;
                            green_q <= onehot(next_way);
                            red_q   <= ~onehot(next_way);
                        end
`else
                        phase_q <= PH_GREEN;
                        way_q   <= next_way;
                        timer_q <= G_LOAD;
                        green_q <= onehot(next_way);
                        red_q   <= ~onehot(next_way);
`endif
                    end
`ifdef TRAFFIC_PED_EN
                    PH_WALK: begin
                        phase_q <= PH_ALL_RED;
                        timer_q <= AR_LOAD;
                        walk_q  <= 1'b0;
                    end
`endif
                    default: begin
                        phase_q  <= PH_ALL_RED;
                        timer_q  <= AR_LOAD;
                        red_q    <= '1;
                        yellow_q <= '0;
                        green_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.red        = red_q;
    assign bus.yellow     = yellow_q;
    assign bus.green      = green_q;
    assign bus.active_way = way_q;
    assign bus.phase      = phase_q;
`ifdef TRAFFIC_PED_EN
    assign bus.walk       = walk_q;
`endif

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed table-driven bench for traffic_phase_sequencer at default parameters.
// The walk-phase sequence is compiled only when TRAFFIC_PED_EN is defined.
module tb_traffic_phase_sequencer;
    import traffic_pkg::*;

    typedef struct {
        bit          rst_row;
        int          n;
        bit          flash;
        logic [1:0]  demand;
        logic [1:0]  red;
        logic [1:0]  yellow;
        logic [1:0]  green;
        logic [2:0]  phase;
        logic        way;
        string       tag;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t tbl[$];

    traffic_phase_sequencer_if #(.N_WAYS(2)) bus ();

    traffic_phase_sequencer #(
        .N_WAYS     (2),
        .GREEN_CYC  (8),
        .YELLOW_CYC (3),
        .ALLRED_CYC (2),
        .FLASH_CYC  (4),
        .WALK_CYC   (6)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] pk(input logic [1:0] r, input logic [1:0] y,
                                      input logic [1:0] g, input logic [2:0] p,
                                      input logic w);
        return {r, y, g, p, w};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got r/y/g/ph/w=%b want %b", name, act, exp);
        end
    endtask

    // One clock edge, then sample 1 ns later and compare against exp.
    task automatic step_chk(input string name, input logic [9:0] exp);
        logic [1:0] gy;
        @(posedge clk);
        #1;
        check(name, {bus.red, bus.yellow, bus.green, bus.phase, bus.active_way}, exp);
        gy = bus.green | bus.yellow;
        if (bus.phase != PH_FLASH) begin
            total++;
            if (!$onehot0(gy)) begin
                bad++;
                $display("FAIL %s_onehot: got green|yellow=%b want at most one bit", name, gy);
            end
        end
    endtask

    task automatic row(input bit rr, input int n, input bit f, input logic [1:0] d,
                       input logic [1:0] r, input logic [1:0] y, input logic [1:0] g,
                       input logic [2:0] p, input logic w, input string tag);
        vec_t v;
        v.rst_row = rr; v.n = n; v.flash = f; v.demand = d;
        v.red = r; v.yellow = y; v.green = g; v.phase = p; v.way = w; v.tag = tag;
        tbl.push_back(v);
    endtask

    localparam logic [2:0] AR = 3'd0, GR = 3'd1, YE = 3'd2, FL = 3'd3, WK = 3'd4;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.flash  = 1'b0;
        bus.demand = 2'b00;
`ifdef TRAFFIC_PED_EN
        bus.ped_req = 1'b0;
`endif

        // rst, n, flash, demand, red, yellow, green, phase, way
        // Test 1: full demand, alternating rotation with 26-cycle period
        row(1, 2, 0, 2'b11, 2'b11, 2'b00, 2'b00, AR, 1'b1, "t1_reset");
        row(0, 1, 0, 2'b11, 2'b11, 2'b00, 2'b00, AR, 1'b1, "t1_ar_init");
        row(0, 8, 0, 2'b11, 2'b10, 2'b00, 2'b01, GR, 1'b0, "t1_g0");
        row(0, 3, 0, 2'b11, 2'b10, 2'b01, 2'b00, YE, 1'b0, "t1_y0");
        row(0, 2, 0, 2'b11, 2'b11, 2'b00, 2'b00, AR, 1'b0, "t1_ar0");
        row(0, 8, 0, 2'b11, 2'b01, 2'b00, 2'b10, GR, 1'b1, "t1_g1");
        row(0, 3, 0, 2'b11, 2'b01, 2'b10, 2'b00, YE, 1'b1, "t1_y1");
        row(0, 2, 0, 2'b11, 2'b11, 2'b00, 2'b00, AR, 1'b1, "t1_ar1");
        row(0, 8, 0, 2'b11, 2'b10, 2'b00, 2'b01, GR, 1'b0, "t1_g0b");
        row(0, 3, 0, 2'b11, 2'b10, 2'b01, 2'b00, YE, 1'b0, "t1_y0b");
        // Test 2: green hold on sole demand, released by the other way
        row(1, 2, 0, 2'b01, 2'b11, 2'b00, 2'b00, AR, 1'b1, "t2_reset");
        row(0, 1, 0, 2'b01, 2'b11, 2'b00, 2'b00, AR, 1'b1, "t2_ar_init");
        row(0, 18, 0, 2'b01, 2'b10, 2'b00, 2'b01, GR, 1'b0, "t2_g0_hold");
        row(0, 3, 0, 2'b11, 2'b10, 2'b01, 2'b00, YE, 1'b0, "t2_y0");
        row(0, 2, 0, 2'b11, 2'b11, 2'b00, 2'b00, AR, 1'b0, "t2_ar0");
        row(0, 8, 0, 2'b11, 2'b01, 2'b00, 2'b10, GR, 1'b1, "t2_g1");
        // Test 3: no demand, plain rotation without hold
        row(1, 2, 0, 2'b00, 2'b11, 2'b00, 2'b00, AR, 1'b1, "t3_reset");
        row(0, 1, 0, 2'b00, 2'b11, 2'b00, 2'b00, AR, 1'b1, "t3_ar_init");
        row(0, 8, 0, 2'b00, 2'b10, 2'b00, 2'b01, GR, 1'b0, "t3_g0");
        row(0, 3, 0, 2'b00, 2'b10, 2'b01, 2'b00, YE, 1'b0, "t3_y0");
        row(0, 2, 0, 2'b00, 2'b11, 2'b00, 2'b00, AR, 1'b0, "t3_ar0");
        row(0, 8, 0, 2'b00, 2'b01, 2'b00, 2'b10, GR, 1'b1, "t3_g1");
        row(0, 3, 0, 2'b00, 2'b01, 2'b10, 2'b00, YE, 1'b1, "t3_y1");
        row(0, 2, 0, 2'b00, 2'b11, 2'b00, 2'b00, AR, 1'b1, "t3_ar1");
        row(0, 8, 0, 2'b00, 2'b10, 2'b00, 2'b01, GR, 1'b0, "t3_g0b");
        // Test 4: flashing yellow entered mid-green, then exit to clearance
        row(1, 2, 0, 2'b11, 2'b11, 2'b00, 2'b00, AR, 1'b1, "t4_reset");
        row(0, 1, 0, 2'b11, 2'b11, 2'b00, 2'b00, AR, 1'b1, "t4_ar_init");
        row(0, 3, 0, 2'b11, 2'b10, 2'b00, 2'b01, GR, 1'b0, "t4_g0");
        row(0, 4, 1, 2'b11, 2'b00, 2'b11, 2'b00, FL, 1'b0, "t4_flash_on");
        row(0, 4, 1, 2'b11, 2'b00, 2'b00, 2'b00, FL, 1'b0, "t4_flash_off");
        row(0, 2, 1, 2'b11, 2'b00, 2'b11, 2'b00, FL, 1'b0, "t4_flash_on2");
        row(0, 2, 0, 2'b11, 2'b11, 2'b00, 2'b00, AR, 1'b1, "t4_ar_exit");
        row(0, 8, 0, 2'b11, 2'b10, 2'b00, 2'b01, GR, 1'b0, "t4_g0_after");
        row(0, 1, 0, 2'b11, 2'b10, 2'b01, 2'b00, YE, 1'b0, "t4_y0");

        foreach (tbl[k]) begin
            bus.flash  = tbl[k].flash;
            bus.demand = tbl[k].demand;
            rst        = tbl[k].rst_row ? 1'b0 : 1'b1;
            for (int i = 0; i < tbl[k].n; i++)
                step_chk(tbl[k].tag, pk(tbl[k].red, tbl[k].yellow, tbl[k].green,
                                        tbl[k].phase, tbl[k].way));
        end

        // Test 5: one-cycle reset in the middle of yellow on way 1
        rst = 1'b0; bus.flash = 1'b0; bus.demand = 2'b11;
        for (int i = 0; i < 2; i++) step_chk("t5_reset", pk(2'b11, 2'b00, 2'b00, AR, 1'b1));
        rst = 1'b1;
        for (int i = 0; i < 22; i++) @(posedge clk);
        #1;
        step_chk("t5_y1_first", pk(2'b01, 2'b10, 2'b00, YE, 1'b1));
        rst = 1'b0;
        step_chk("t5_mid_reset", pk(2'b11, 2'b00, 2'b00, AR, 1'b1));
        rst = 1'b1;
        step_chk("t5_ar_after", pk(2'b11, 2'b00, 2'b00, AR, 1'b1));
        step_chk("t5_g0_after", pk(2'b10, 2'b00, 2'b01, GR, 1'b0));

`ifdef TRAFFIC_PED_EN
        // Test 6: single-cycle pedestrian press during green on way 0
        rst = 1'b0; bus.demand = 2'b11;
        for (int i = 0; i < 2; i++) step_chk("t6_reset", pk(2'b11, 2'b00, 2'b00, AR, 1'b1));
        rst = 1'b1;
        step_chk("t6_ar_init", pk(2'b11, 2'b00, 2'b00, AR, 1'b1));
        for (int i = 0; i < 3; i++) step_chk("t6_g0", pk(2'b10, 2'b00, 2'b01, GR, 1'b0));
        bus.ped_req = 1'b1;
        step_chk("t6_g0_press", pk(2'b10, 2'b00, 2'b01, GR, 1'b0));
        bus.ped_req = 1'b0;
        for (int i = 0; i < 4; i++) step_chk("t6_g0", pk(2'b10, 2'b00, 2'b01, GR, 1'b0));
        for (int i = 0; i < 3; i++) step_chk("t6_y0", pk(2'b10, 2'b01, 2'b00, YE, 1'b0));
        for (int i = 0; i < 2; i++) step_chk("t6_ar0", pk(2'b11, 2'b00, 2'b00, AR, 1'b0));
        for (int i = 0; i < 6; i++) begin
            step_chk("t6_walk", pk(2'b11, 2'b00, 2'b00, WK, 1'b0));
            total++;
            if (bus.walk !== 1'b1) begin
                bad++;
                $display("FAIL t6_walk_lamp: got %b want 1", bus.walk);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step_chk("t6_ar_post", pk(2'b11, 2'b00, 2'b00, AR, 1'b0));
            total++;
            if (bus.walk !== 1'b0) begin
                bad++;
                $display("FAIL t6_walk_off: got %b want 0", bus.walk);
            end
        end
        step_chk("t6_g1", pk(2'b01, 2'b00, 2'b10, GR, 1'b1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
